// File: rtl/ifu_fetch_if.sv
// Fetch-unit boundary: PC input, read-address/read-data bus and the IDU handoff.
// Signal names are as seen from the fetch unit (master side).
interface ifu_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_pc;
  logic              i_pc_valid;
  logic [ADDR_W-1:0] o_araddr;
  logic              o_arvalid;
  logic              i_arready;
  logic [DATA_W-1:0] i_rdata;
  logic [1:0]        i_rresp;
  logic              i_rvalid;
  logic              o_rready;
  logic [DATA_W-1:0] o_inst;
  logic [ADDR_W-1:0] o_inst_pc;
  logic              o_fetch_err;
  logic              o_ifu_valid;
  logic              i_idu_ready;

  modport master (
    input  i_pc, i_pc_valid, i_arready, i_rdata, i_rresp, i_rvalid, i_idu_ready,
    output o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_fetch_err, o_ifu_valid
  );

  modport slave (
    output i_pc, i_pc_valid, i_arready, i_rdata, i_rresp, i_rvalid, i_idu_ready,
    input  o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_fetch_err, o_ifu_valid
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one bus read per new PC, result handed to decode over valid/ready.
// A PC arriving while a fetch is in flight is parked (newest wins) and launched on the IDU handshake.
module ifu_fetch #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter bit FETCH_ON_RST = 1'b1
) (
  input logic         i_clk,
  input logic         i_rst,
  ifu_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;

  state_t            r_state;
  logic              r_first;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] r_araddr;
  logic              r_arvalid;
  logic              r_rready;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_fetch_err;
  logic              r_ifu_valid;

  logic              w_hs;
  logic              w_launch;
  logic [ADDR_W-1:0] w_launch_pc;
  logic              w_misalign;

  assign w_hs = (r_state == OUT) && bus.i_idu_ready;

  // A fresh pulse always beats a parked PC.
  assign w_launch_pc = bus.i_pc_valid ? bus.i_pc : (r_pend ? r_pend_pc : bus.i_pc);
  assign w_misalign  = (w_launch_pc[1:0] != 2'b00);

  always_comb begin
    w_launch = 1'b0;
    case (r_state)
      IDLE:    w_launch = bus.i_pc_valid | r_pend | r_first;
      OUT:     w_launch = w_hs & (bus.i_pc_valid | r_pend);
      default: w_launch = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_first     <= FETCH_ON_RST;
      r_pend      <= 1'b0;
      r_pend_pc   <= '0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      r_fetch_err <= 1'b0;
      r_ifu_valid <= 1'b0;
    end else begin
      r_first <= 1'b0;

      if (w_launch) begin
        r_pend    <= 1'b0;
        r_araddr  <= w_launch_pc;
        r_inst_pc <= w_launch_pc;
        if (w_misalign) begin
          r_state     <= OUT;
          r_inst      <= '0;
          r_fetch_err <= 1'b1;
          r_ifu_valid <= 1'b1;
          r_arvalid   <= 1'b0;
        end else begin
          r_state     <= AR;
          r_fetch_err <= 1'b0;
          r_ifu_valid <= 1'b0;
          r_arvalid   <= 1'b1;
        end
      end else begin
        if (bus.i_pc_valid) begin
          r_pend    <= 1'b1;
          r_pend_pc <= bus.i_pc;
        end
        case (r_state)
          AR: if (bus.i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
          end
          R: if (bus.i_rvalid) begin
            r_rready    <= 1'b0;
            r_fetch_err <= (bus.i_rresp != 2'b00);
            r_inst      <= (bus.i_rresp != 2'b00) ? '0 : bus.i_rdata;
            r_ifu_valid <= 1'b1;
            r_state     <= OUT;
          end
          OUT: if (w_hs) begin
            r_ifu_valid <= 1'b0;
            r_state     <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_araddr    = r_araddr;
  assign bus.o_arvalid   = r_arvalid;
  assign bus.o_rready    = r_rready;
  assign bus.o_inst      = r_inst;
  assign bus.o_inst_pc   = r_inst_pc;
  assign bus.o_fetch_err = r_fetch_err;
  assign bus.o_ifu_valid = r_ifu_valid;
endmodule
